// File: rtl/tm_pkg.sv
// rtl/tm_pkg.sv - Shared types and constants for the Tsetlin Machine trainer.
package tm_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_PICK,
    ST_UPD,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    FB_NONE,
    FB_TYPE1,
    FB_TYPE2
  } fb_e;

  // Weakest exclude: one increment away from include.
  function automatic int ta_init(input int ta_bits);
    return (1 << (ta_bits - 1)) - 1;
  endfunction

  // Literal vector is {features, ~features}: plain features sit in the upper half.
  function automatic int lit_idx(input int n_features, input int feat, input bit negated);
    return negated ? feat : n_features + feat;
  endfunction

  function automatic int excl_idx(input int c, input int j, input int k,
                                  input int n_clauses, input int n_lit);
    return (c * n_clauses + j) * n_lit + k;
  endfunction

endpackage

// File: rtl/tm_trainer_if.sv
// rtl/tm_trainer_if.sv - Labelled-sample handshake channel into the trainer.
interface tm_trainer_if #(
  parameter int N_FEATURES = 2,
  parameter int N_CLASSES  = 2
);
  localparam int LB = $clog2(N_CLASSES);

  logic                  sample_valid;
  logic                  sample_ready;
  logic [N_FEATURES-1:0] sample_feat;
  logic [LB-1:0]         sample_label;

  modport master (output sample_valid, output sample_feat, output sample_label, input sample_ready);
  modport slave  (input sample_valid, input sample_feat, input sample_label, output sample_ready);
endinterface

// File: rtl/tm_lfsr.sv
// rtl/tm_lfsr.sv - 32-bit right-shifting Galois LFSR with reset seed and advance enable.
module tm_lfsr
  import tm_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_5EED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] state_o
);
  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else if (en_i) begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/tm_trainer.sv
// rtl/tm_trainer.sv - Tsetlin Machine trainer: TA banks, training FSM, exclude-mask output.
// Optional macro TM_BOOST_TRUE_POS_EN: Type I true-positive literals always increment.
module tm_trainer
  import tm_pkg::*;
#(
  parameter int          N_FEATURES = 2,
  parameter int          N_CLASSES  = 2,
  parameter int          N_CLAUSES  = 4,
  parameter int          TA_BITS    = 4,
  parameter int          S_LOG2     = 2,
  parameter int          T_LOG2     = 1,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_5EED
) (
  input  logic                                      clk,
  input  logic                                      rst,
  tm_trainer_if.slave                               smp,
  output logic [N_CLASSES*N_CLAUSES*2*N_FEATURES-1:0] exclude_state,
  output logic                                      busy,
  output logic                                      train_done
);
  localparam int N_LIT  = 2 * N_FEATURES;
  localparam int LB     = $clog2(N_CLASSES);
  localparam int CW     = $clog2(2 * N_CLAUSES);
  localparam int T      = 1 << T_LOG2;
  localparam int N_EXCL = N_CLASSES * N_CLAUSES * N_LIT;
  localparam logic [TA_BITS-1:0] TA_MAX = '1;
  localparam logic [TA_BITS-1:0] TA_RST = TA_BITS'(ta_init(TA_BITS));
`ifdef TM_BOOST_TRUE_POS_EN
  localparam bit BOOST = 1'b1;
`else
  localparam bit BOOST = 1'b0;
`endif

  state_e                state_q;
  logic                  ready_q, busy_q, done_q;
  logic [N_FEATURES-1:0] feat_q;
  logic [LB-1:0]         label_q, neg_q, neg_d;
  logic [CW-1:0]         cnt_q;
  logic [TA_BITS-1:0]    ta_q [N_CLASSES][N_CLAUSES][N_LIT];
  logic [TA_BITS-1:0]    ta_d [N_CLASSES][N_CLAUSES][N_LIT];
  logic [N_CLAUSES-1:0]  clause_q [N_CLASSES];
  logic [N_CLAUSES-1:0]  clause_d [N_CLASSES];
  logic signed [15:0]    vote_q [N_CLASSES];
  logic signed [15:0]    vote_d [N_CLASSES];
  logic [N_EXCL-1:0]     excl_q, excl_d;
  logic [N_LIT-1:0]      lits;
  logic [31:0]           lfsr;
  logic                  unused_lfsr;

  tm_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .en_i(1'b1), .state_o(lfsr));
  assign unused_lfsr = ^lfsr;

  always_comb begin
    lits = '0;
    for (int i = 0; i < N_FEATURES; i++) begin
      lits[lit_idx(N_FEATURES, i, 1'b0)] = feat_q[i];
      lits[lit_idx(N_FEATURES, i, 1'b1)] = ~feat_q[i];
    end
  end

  // Clause evaluation and clamped votes; latched once per sample in EVAL.
  always_comb begin : eval_comb
    int acc;
    for (int c = 0; c < N_CLASSES; c++) begin
      acc = 0;
      clause_d[c] = '1;
      for (int j = 0; j < N_CLAUSES; j++) begin
        for (int k = 0; k < N_LIT; k++) begin
          if (ta_q[c][j][k][TA_BITS-1] && !lits[k]) clause_d[c][j] = 1'b0;
        end
        if (clause_d[c][j]) acc = acc + ((j >= N_CLAUSES / 2) ? 1 : -1);
      end
      if (acc > T) acc = T;
      else if (acc < -T) acc = -T;
      vote_d[c] = 16'(acc);
    end
  end

  always_comb begin
    neg_d = lfsr[LB-1:0];
    if (neg_d == '0) neg_d = LB'(1);
    neg_d = neg_d ^ label_q;
  end

  always_comb begin : upd_comb
    logic               tgt, gate, co, inc, dec;
    logic [LB-1:0]      cls;
    int                 sel, v, r2;
    fb_e                fb;
    logic [TA_BITS-1:0] t;
    logic [S_LOG2-1:0]  rk;
    ta_d = ta_q;
    t    = '0;
    rk   = '0;
    inc  = 1'b0;
    dec  = 1'b0;
    tgt  = (int'(cnt_q) < N_CLAUSES);
    cls  = tgt ? label_q : neg_q;
    sel  = N_CLAUSES - 1 - (tgt ? int'(cnt_q) : int'(cnt_q) - N_CLAUSES);
    v    = int'(vote_q[cls]);
    r2   = int'(lfsr[31 -: T_LOG2+1]);
    gate = tgt ? (r2 < T - v) : (r2 < T + v);
    co   = clause_q[cls][sel];
    // Type I rewards target-positive and punishes-by-pattern neg-negative clauses.
    if (!gate || state_q != ST_UPD) fb = FB_NONE;
    else if (tgt == (sel >= N_CLAUSES / 2)) fb = FB_TYPE1;
    else fb = FB_TYPE2;
    for (int c = 0; c < N_CLASSES; c++) begin
      for (int j = 0; j < N_CLAUSES; j++) begin
        for (int k = 0; k < N_LIT; k++) begin
          if (fb != FB_NONE && c == int'(cls) && j == sel) begin
            t   = ta_q[c][j][k];
            rk  = lfsr[k*S_LOG2 +: S_LOG2];
            inc = 1'b0;
            dec = 1'b0;
            if (fb == FB_TYPE1) begin
              if (co && lits[k]) inc = BOOST || (rk != '0);
              else dec = (rk == '0);
            end else begin
              inc = co && !lits[k] && !t[TA_BITS-1];
            end
            if (inc && t != TA_MAX) ta_d[c][j][k] = t + 1'b1;
            else if (dec && t != '0) ta_d[c][j][k] = t - 1'b1;
          end
        end
      end
    end
    excl_d = '0;
    for (int c = 0; c < N_CLASSES; c++)
      for (int j = 0; j < N_CLAUSES; j++)
        for (int k = 0; k < N_LIT; k++)
          excl_d[excl_idx(c, j, k, N_CLAUSES, N_LIT)] = ~ta_d[c][j][k][TA_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      feat_q  <= '0;
      label_q <= '0;
      neg_q   <= '0;
      excl_q  <= '1;
      for (int c = 0; c < N_CLASSES; c++) begin
        clause_q[c] <= '0;
        vote_q[c]   <= '0;
        for (int j = 0; j < N_CLAUSES; j++)
          for (int k = 0; k < N_LIT; k++)
            ta_q[c][j][k] <= TA_RST;
      end
    end else begin
      ta_q   <= ta_d;
      excl_q <= excl_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (smp.sample_valid) begin
          feat_q  <= smp.sample_feat;
          label_q <= smp.sample_label;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          clause_q <= clause_d;
          vote_q   <= vote_d;
          state_q  <= ST_PICK;
        end
        ST_PICK: begin
          neg_q   <= neg_d;
          cnt_q   <= '0;
          state_q <= ST_UPD;
        end
        ST_UPD: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(2 * N_CLAUSES - 1)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign smp.sample_ready = ready_q;
  assign busy             = busy_q;
  assign train_done       = done_q;
  assign exclude_state    = excl_q;
endmodule

// File: tb/tb_tm_trainer.sv
// tb/tb_tm_trainer.sv - Scoreboard bench for tm_trainer with an independent TA/LFSR model.
module tb_tm_trainer;
  localparam logic [31:0] SEED = 32'hACE1_5EED;
`ifdef TM_BOOST_TRUE_POS_EN
  localparam bit BOOST = 1'b1;
`else
  localparam bit BOOST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] exclude_state;
  logic        busy;
  logic        train_done;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] lm;
  logic [31:0] exp_q [$];
  int          ta [2][4][4];

  tm_trainer_if #(.N_FEATURES(2), .N_CLASSES(2)) smp_if ();

  tm_trainer dut (
    .clk(clk),
    .rst(rst),
    .smp(smp_if),
    .exclude_state(exclude_state),
    .busy(busy),
    .train_done(train_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    lm  <= rst ? SEED : lstep(lm);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          ta[c][j][k] = 7;
  endtask

  task automatic model_train(input logic [1:0] f, input logic lab, input logic [31:0] l0,
                             output logic [31:0] ex);
    logic [3:0]  lits;
    logic [31:0] l;
    int          fired [2][4];
    int          vote [2];
    logic        r, neg, cls;
    int          j, r2, rk, t;
    bit          tgt, gate, type1, inc, dec;
    lits = {f, ~f};
    for (int c = 0; c < 2; c++) begin
      vote[c] = 0;
      for (int jj = 0; jj < 4; jj++) begin
        fired[c][jj] = 1;
        for (int k = 0; k < 4; k++)
          if (ta[c][jj][k] >= 8 && !lits[k]) fired[c][jj] = 0;
        if (fired[c][jj] == 1) vote[c] += (jj >= 2) ? 1 : -1;
      end
      if (vote[c] > 2) vote[c] = 2;
      if (vote[c] < -2) vote[c] = -2;
    end
    l = lstep(lstep(l0));
    r = l[0];
    if (!r) r = 1'b1;
    neg = lab ^ r;
    for (int i = 0; i < 8; i++) begin
      l    = lstep(l);
      tgt  = (i < 4);
      cls  = tgt ? lab : neg;
      j    = 3 - (i % 4);
      r2   = int'(l[31:30]);
      gate = tgt ? (r2 < 2 - vote[cls]) : (r2 < 2 + vote[cls]);
      type1 = (tgt && j >= 2) || (!tgt && j < 2);
      if (gate) begin
        for (int k = 0; k < 4; k++) begin
          rk  = int'((l >> (2 * k)) & 32'h3);
          t   = ta[cls][j][k];
          inc = 0;
          dec = 0;
          if (type1) begin
            if (fired[cls][j] == 0) dec = (rk == 0);
            else if (lits[k]) inc = BOOST || (rk != 0);
            else dec = (rk == 0);
          end else if (fired[cls][j] == 1 && !lits[k] && t < 8) begin
            inc = 1;
          end
          if (inc && t < 15) t++;
          if (dec && t > 0) t--;
          ta[cls][j][k] = t;
        end
      end
    end
    for (int c = 0; c < 2; c++)
      for (int jj = 0; jj < 4; jj++)
        for (int k = 0; k < 4; k++)
          ex[(c * 4 + jj) * 4 + k] = (ta[c][jj][k] < 8);
  endtask

  // Call at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] f, input logic lab, input bit exp_done, output int acc_edge);
    logic [31:0] e;
    int          t;
    smp_if.sample_feat  = f;
    smp_if.sample_label = lab;
    smp_if.sample_valid = 1'b1;
    t = 0;
    while (smp_if.sample_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      chk("accept_timeout", 32'(t), 32'd0);
      acc_edge = -1;
      smp_if.sample_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    if (exp_done) begin
      model_train(f, lab, lm, e);
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    smp_if.sample_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (train_done === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_train_done: got pulse with exclude 0x%0h, expected no pulse", exclude_state);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (exclude_state !== e) begin
          n_bad++;
          $display("FAIL exclude_state: got 0x%0h, expected 0x%0h", exclude_state, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, em, ed, pulses, t;
    rst = 1'b1;
    smp_if.sample_valid = 1'b0;
    smp_if.sample_feat  = '0;
    smp_if.sample_label = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exclude", exclude_state, 32'hFFFF_FFFF);
    chk("rst_ready", 32'(smp_if.sample_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(train_done), 32'd0);

    // Latency and backpressure: second sample held valid while busy.
    send(2'b10, 1'b0, 1'b1, ea);
    smp_if.sample_feat  = 2'b01;
    smp_if.sample_label = 1'b1;
    smp_if.sample_valid = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_done", 32'(train_done), 32'(k == 11));
      chk("lat_ready", 32'(smp_if.sample_ready), 32'd0);
      @(negedge clk);
    end
    chk("lat_ready_c12", 32'(smp_if.sample_ready), 32'd1);
    chk("lat_busy_c12", 32'(busy), 32'd0);
    chk("lat_done_c12", 32'(train_done), 32'd0);
    send(2'b01, 1'b1, 1'b1, eb);
    chk("accept_cycle", 32'(eb - ea), 32'd12);

    for (int i = 0; i < 500; i++)
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, ed);

    for (int i = 0; i < 300; i++)
      send(2'b11, 1'b1, 1'b1, ed);

    // Abort in the sixth UPD cycle.
    send(2'b10, 1'b1, 1'b0, em);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_exclude", exclude_state, 32'hFFFF_FFFF);
    chk("abort_ready", 32'(smp_if.sample_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(train_done), 32'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (train_done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    send(2'b11, 1'b0, 1'b1, ed);
    send(2'b00, 1'b1, 1'b1, ed);
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
